// File: rtl/atmos_light_est.sv
// Atmospheric-light estimator for the dehaze front end.
// During each frame it keeps a sorted list of the TOP_K pixels whose dark
// channel, min(r,g,b), is brightest. When a frame ends, it averages those
// pixels per colour and folds the average into A_* through an IIR step.
//
// state  | meaning
// -------+-------------------------------------------------------------
// ACCUM  | idle; the live list collects pixels; waiting for a vsync rise
// SUM    | walk the shadow list, one entry per cycle, into accumulators
// DIV    | average = sum >> LOG2_K; an empty frame returns to ACCUM
// UPDATE | load or smooth A_*, pulse valid_out
module atmos_light_est #(
  parameter int DATA_WIDTH  = 8,
  parameter int TOP_K       = 8,
  parameter int ALPHA_SHIFT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vsync,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] r_in,
  input  logic [DATA_WIDTH-1:0] g_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  output logic [DATA_WIDTH-1:0] A_r,
  output logic [DATA_WIDTH-1:0] A_g,
  output logic [DATA_WIDTH-1:0] A_b,
  output logic                  valid_out,
  output logic                  busy
);

  localparam int LOG2_K = $clog2(TOP_K);
  localparam int SUM_W  = DATA_WIDTH + LOG2_K;
  localparam int CNT_W  = LOG2_K + 1;
  localparam int IDX_W  = (LOG2_K > 0) ? LOG2_K : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TOP_K - 1);

  localparam logic [1:0] S_ACCUM  = 2'd0;
  localparam logic [1:0] S_SUM    = 2'd1;
  localparam logic [1:0] S_DIV    = 2'd2;
  localparam logic [1:0] S_UPDATE = 2'd3;

  // live top-K list, sorted descending by dark value
  logic                  live_v_q  [TOP_K];
  logic [DATA_WIDTH-1:0] live_dk_q [TOP_K];
  logic [DATA_WIDTH-1:0] live_r_q  [TOP_K];
  logic [DATA_WIDTH-1:0] live_g_q  [TOP_K];
  logic [DATA_WIDTH-1:0] live_b_q  [TOP_K];
  logic                  live_v_d  [TOP_K];
  logic [DATA_WIDTH-1:0] live_dk_d [TOP_K];
  logic [DATA_WIDTH-1:0] live_r_d  [TOP_K];
  logic [DATA_WIDTH-1:0] live_g_d  [TOP_K];
  logic [DATA_WIDTH-1:0] live_b_d  [TOP_K];

  // frozen copy of the list taken at frame end
  logic                  sh_v_q [TOP_K];
  logic [DATA_WIDTH-1:0] sh_r_q [TOP_K];
  logic [DATA_WIDTH-1:0] sh_g_q [TOP_K];
  logic [DATA_WIDTH-1:0] sh_b_q [TOP_K];

  logic                  base_v [TOP_K];
  logic                  gt     [TOP_K];
  logic [DATA_WIDTH-1:0] px_dark;

  logic                  vsync_q;
  logic                  snap;

  logic [1:0]            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [SUM_W-1:0]      sum_r_q, sum_g_q, sum_b_q;
  logic [SUM_W-1:0]      sum_r_d, sum_g_d, sum_b_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] avg_r_q, avg_g_q, avg_b_q;
  logic [DATA_WIDTH-1:0] avg_r_d, avg_g_d, avg_b_d;
  logic [DATA_WIDTH-1:0] a_r_q, a_g_q, a_b_q;
  logic [DATA_WIDTH-1:0] a_r_d, a_g_d, a_b_d;
  logic                  first_q, first_d;
  logic                  valid_out_q, valid_out_d;

  // A += (avg - A) >>> ALPHA_SHIFT; the true result always lies between A
  // and avg, so modular DATA_WIDTH arithmetic gives the exact value.
  function automatic logic [DATA_WIDTH-1:0] iir_step(
    input logic [DATA_WIDTH-1:0] a_cur,
    input logic [DATA_WIDTH-1:0] avg
  );
    logic signed [DATA_WIDTH:0] diff;
    logic signed [DATA_WIDTH:0] step;
    diff = $signed({1'b0, avg}) - $signed({1'b0, a_cur});
    step = diff >>> ALPHA_SHIFT;
    return a_cur + step[DATA_WIDTH-1:0];
  endfunction

  // A frame ends only on a vsync rise seen while idle; later rises merge frames.
  assign snap = vsync & ~vsync_q & (state_q == S_ACCUM);

  // Dark channel of the incoming pixel
  always_comb begin
    px_dark = r_in;
    if (g_in < px_dark) px_dark = g_in;
    if (b_in < px_dark) px_dark = b_in;
  end

  // Sorted insertion; on the snapshot cycle the new pixel lands in an empty list.
  // gt[] is monotonic (false..true) because the list is sorted with invalids last.
  always_comb begin
    for (int i = 0; i < TOP_K; i++) begin
      base_v[i]    = live_v_q[i] & ~snap;
      gt[i]        = valid_in & (~base_v[i] | (px_dark > live_dk_q[i]));
      live_v_d[i]  = base_v[i];
      live_dk_d[i] = live_dk_q[i];
      live_r_d[i]  = live_r_q[i];
      live_g_d[i]  = live_g_q[i];
      live_b_d[i]  = live_b_q[i];
    end
    if (gt[0]) begin
      live_v_d[0]  = 1'b1;
      live_dk_d[0] = px_dark;
      live_r_d[0]  = r_in;
      live_g_d[0]  = g_in;
      live_b_d[0]  = b_in;
    end
    for (int i = 1; i < TOP_K; i++) begin
      if (gt[i]) begin
        if (!gt[i-1]) begin
          live_v_d[i]  = 1'b1;
          live_dk_d[i] = px_dark;
          live_r_d[i]  = r_in;
          live_g_d[i]  = g_in;
          live_b_d[i]  = b_in;
        end else begin
          live_v_d[i]  = base_v[i-1];
          live_dk_d[i] = live_dk_q[i-1];
          live_r_d[i]  = live_r_q[i-1];
          live_g_d[i]  = live_g_q[i-1];
          live_b_d[i]  = live_b_q[i-1];
        end
      end
    end
  end

  // Live list registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TOP_K; i++) begin
        live_v_q[i]  <= 1'b0;
        live_dk_q[i] <= '0;
        live_r_q[i]  <= '0;
        live_g_q[i]  <= '0;
        live_b_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < TOP_K; i++) begin
        live_v_q[i]  <= live_v_d[i];
        live_dk_q[i] <= live_dk_d[i];
        live_r_q[i]  <= live_r_d[i];
        live_g_q[i]  <= live_g_d[i];
        live_b_q[i]  <= live_b_d[i];
      end
    end
  end

  // Shadow list: captures the finished frame before the live list is cleared
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TOP_K; i++) begin
        sh_v_q[i] <= 1'b0;
        sh_r_q[i] <= '0;
        sh_g_q[i] <= '0;
        sh_b_q[i] <= '0;
      end
    end else if (snap) begin
      for (int i = 0; i < TOP_K; i++) begin
        sh_v_q[i] <= live_v_q[i];
        sh_r_q[i] <= live_r_q[i];
        sh_g_q[i] <= live_g_q[i];
        sh_b_q[i] <= live_b_q[i];
      end
    end
  end

  // Frame-end sequencer: sum, divide, update
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    sum_r_d     = sum_r_q;
    sum_g_d     = sum_g_q;
    sum_b_d     = sum_b_q;
    cnt_d       = cnt_q;
    avg_r_d     = avg_r_q;
    avg_g_d     = avg_g_q;
    avg_b_d     = avg_b_q;
    a_r_d       = a_r_q;
    a_g_d       = a_g_q;
    a_b_d       = a_b_q;
    first_d     = first_q;
    valid_out_d = 1'b0;
    case (state_q)
      S_ACCUM: begin
        if (snap) begin
          state_d = S_SUM;
          idx_d   = '0;
          sum_r_d = '0;
          sum_g_d = '0;
          sum_b_d = '0;
          cnt_d   = '0;
        end
      end
      S_SUM: begin
        if (sh_v_q[idx_q]) begin
          sum_r_d = sum_r_q + SUM_W'(sh_r_q[idx_q]);
          sum_g_d = sum_g_q + SUM_W'(sh_g_q[idx_q]);
          sum_b_d = sum_b_q + SUM_W'(sh_b_q[idx_q]);
          cnt_d   = cnt_q + CNT_W'(1);
        end
        if (idx_q == IDX_LAST) begin
          state_d = S_DIV;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DIV: begin
        // invalid slots count as zero, so partial frames come out low
        avg_r_d = DATA_WIDTH'(sum_r_q >> LOG2_K);
        avg_g_d = DATA_WIDTH'(sum_g_q >> LOG2_K);
        avg_b_d = DATA_WIDTH'(sum_b_q >> LOG2_K);
        state_d = (cnt_q == '0) ? S_ACCUM : S_UPDATE;
      end
      default: begin
        if (first_q) begin
          a_r_d = avg_r_q;
          a_g_d = avg_g_q;
          a_b_d = avg_b_q;
        end else begin
          a_r_d = iir_step(a_r_q, avg_r_q);
          a_g_d = iir_step(a_g_q, avg_g_q);
          a_b_d = iir_step(a_b_q, avg_b_q);
        end
        first_d     = 1'b0;
        valid_out_d = 1'b1;
        state_d     = S_ACCUM;
      end
    endcase
  end

  // Sequencer and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q     <= 1'b0;
      state_q     <= S_ACCUM;
      idx_q       <= '0;
      sum_r_q     <= '0;
      sum_g_q     <= '0;
      sum_b_q     <= '0;
      cnt_q       <= '0;
      avg_r_q     <= '0;
      avg_g_q     <= '0;
      avg_b_q     <= '0;
      a_r_q       <= '0;
      a_g_q       <= '0;
      a_b_q       <= '0;
      first_q     <= 1'b1;
      valid_out_q <= 1'b0;
    end else begin
      vsync_q     <= vsync;
      state_q     <= state_d;
      idx_q       <= idx_d;
      sum_r_q     <= sum_r_d;
      sum_g_q     <= sum_g_d;
      sum_b_q     <= sum_b_d;
      cnt_q       <= cnt_d;
      avg_r_q     <= avg_r_d;
      avg_g_q     <= avg_g_d;
      avg_b_q     <= avg_b_d;
      a_r_q       <= a_r_d;
      a_g_q       <= a_g_d;
      a_b_q       <= a_b_d;
      first_q     <= first_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign A_r       = a_r_q;
  assign A_g       = a_g_q;
  assign A_b       = a_b_q;
  assign valid_out = valid_out_q;
  assign busy      = (state_q == S_SUM) || (state_q == S_DIV);

endmodule

// File: tb/tb_atmos_light_est.sv
// Bench for atmos_light_est: a reference model ranks each frame's pixels,
// queues the expected A_* and arrival cycle, and a monitor checks valid_out.
module tb_atmos_light_est;
  localparam int DW = 8;
  localparam int K  = 8;
  localparam int AS = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vsync = 1'b0;
  logic          valid_in = 1'b0;
  logic [DW-1:0] r_in = '0, g_in = '0, b_in = '0;
  logic [DW-1:0] A_r, A_g, A_b;
  logic          valid_out, busy;

  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;

  typedef struct {int cyc; int r; int g; int b;} exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  int m_a[3];
  bit m_first;
  int px_r[$], px_g[$], px_b[$];

  atmos_light_est #(.DATA_WIDTH(DW), .TOP_K(K), .ALPHA_SHIFT(AS)) dut (
    .clk(clk), .rst(rst), .vsync(vsync), .valid_in(valid_in),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .A_r(A_r), .A_g(A_g), .A_b(A_b),
    .valid_out(valid_out), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int min3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b < m) m = b;
    if (c < m) m = c;
    return m;
  endfunction

  task automatic model_reset();
    m_a = '{0, 0, 0};
    m_first = 1'b1;
    px_r.delete();
    px_g.delete();
    px_b.delete();
  endtask

  task automatic add_px(input int r, input int g, input int b);
    px_r.push_back(r);
    px_g.push_back(g);
    px_b.push_back(b);
  endtask

  // Pick the K largest dark values, earliest pixel winning ties, then average.
  task automatic model_end(input int t);
    int n;
    int best, bd, d, cnt;
    int s[3];
    int avg[3];
    bit used[$];
    n = px_r.size();
    cnt = 0;
    s = '{0, 0, 0};
    for (int j = 0; j < n; j++) used.push_back(1'b0);
    for (int k = 0; k < K; k++) begin
      best = -1;
      bd = -1;
      for (int j = 0; j < n; j++) begin
        d = min3(px_r[j], px_g[j], px_b[j]);
        if (!used[j] && d > bd) begin
          best = j;
          bd = d;
        end
      end
      if (best >= 0) begin
        used[best] = 1'b1;
        s[0] += px_r[best];
        s[1] += px_g[best];
        s[2] += px_b[best];
        cnt++;
      end
    end
    px_r.delete();
    px_g.delete();
    px_b.delete();
    if (cnt == 0) return;
    for (int c = 0; c < 3; c++) begin
      avg[c] = s[c] / K;
      if (m_first) m_a[c] = avg[c];
      else         m_a[c] = m_a[c] + ((avg[c] - m_a[c]) >>> AS);
    end
    m_first = 1'b0;
    exp_q.push_back('{t + K + 3, m_a[0], m_a[1], m_a[2]});
  endtask

  task automatic send_px(input int r, input int g, input int b);
    valid_in = 1'b1;
    r_in = DW'(r);
    g_in = DW'(g);
    b_in = DW'(b);
    add_px(r, g, b);
    tick(1);
    valid_in = 1'b0;
  endtask

  // Raise vsync (left high); an optional pixel in the same cycle opens the next frame.
  task automatic vs_rise(input bit with_px, input int r = 0, input int g = 0, input int b = 0);
    vsync = 1'b1;
    model_end(cyc);
    if (with_px) begin
      valid_in = 1'b1;
      r_in = DW'(r);
      g_in = DW'(g);
      b_in = DW'(b);
      add_px(r, g, b);
    end
    tick(1);
    valid_in = 1'b0;
  endtask

  // Scoreboard: each queued result must appear exactly in its cycle, nothing else.
  always @(negedge clk) begin
    if (exp_q.size() > 0 && cyc == exp_q[0].cyc) begin
      mon_e = exp_q.pop_front();
      chk("valid_out_due", {31'b0, valid_out}, 1);
      chk("result_A_r", {24'b0, A_r}, mon_e.r);
      chk("result_A_g", {24'b0, A_g}, mon_e.g);
      chk("result_A_b", {24'b0, A_b}, mon_e.b);
    end else if (valid_out !== 1'b0) begin
      chk("valid_out_unexpected", {31'b0, valid_out}, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, failures so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    model_reset();
    tick(2);
    rst = 1'b0;
    tick(1);

    // bright pixels that a mid-stream reset must discard
    for (int i = 0; i < 4; i++) send_px(250, 250, 250);
    rst = 1'b1;
    tick(2);
    chk("reset_A_r", A_r, 0);
    chk("reset_A_g", A_g, 0);
    chk("reset_A_b", A_b, 0);
    chk("reset_valid_out", valid_out, 0);
    chk("reset_busy", busy, 0);
    rst = 1'b0;
    model_reset();

    // first frame: top 8 of 10..160 -> 125, busy t+1..t+K+1
    for (int i = 1; i <= 16; i++) send_px(10 * i, 10 * i, 10 * i);
    vsync = 1'b1;
    t = cyc;
    model_end(t);
    chk("busy_at_t", busy, 0);
    tick(1);
    vsync = 1'b0;
    for (int n = 1; n <= K + 1; n++) begin
      chk("busy_sum_div", busy, 1);
      tick(1);
    end
    chk("busy_after_div", busy, 0);
    tick(1);
    chk("f1_A_r", A_r, 125);
    chk("f1_A_g", A_g, 125);
    chk("f1_A_b", A_b, 125);
    tick(1);
    chk("f1_pulse_width", valid_out, 0);

    // second frame of 45s, vsync held high while the third frame streams in
    for (int i = 0; i < 10; i++) send_px(45, 45, 45);
    vs_rise(1'b1, 45, 45, 45);
    for (int i = 0; i < 11; i++) send_px(45, 45, 45);
    chk("f2_A_r", A_r, 105);
    chk("f2_A_g", A_g, 105);
    chk("f2_A_b", A_b, 105);
    vsync = 1'b0;
    tick(1);
    vs_rise(1'b0);
    vsync = 1'b0;
    tick(12);
    chk("f3_A_r", A_r, 90);
    chk("f3_A_g", A_g, 90);
    chk("f3_A_b", A_b, 90);

    // empty frame, then a rise during busy that must be ignored (frames merge)
    vs_rise(1'b0);
    vsync = 1'b0;
    tick(1);
    vsync = 1'b1;
    chk("busy_at_ignored_rise", busy, 1);
    tick(1);
    vsync = 1'b0;
    for (int i = 0; i < 4; i++) send_px(100, 120, 140);
    tick(8);
    chk("empty_A_r_held", A_r, 90);
    for (int i = 0; i < 4; i++) send_px(200, 200, 200);
    vs_rise(1'b0);
    vsync = 1'b0;
    tick(12);
    chk("merged_A_r", A_r, 105);
    chk("merged_A_g", A_g, 107);
    chk("merged_A_b", A_b, 110);

    // partial frame after fresh reset
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) send_px(200, 210, 220);
    for (int i = 0; i < 10; i++) send_px(5, 5, 5);
    vs_rise(1'b0);
    vsync = 1'b0;
    tick(12);
    chk("partial_A_r", A_r, 78);
    chk("partial_A_g", A_g, 81);
    chk("partial_A_b", A_b, 85);

    // ties at dark=5: the earliest five (b=5..9) must survive
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) send_px(200, 210, 220);
    for (int j = 0; j < 10; j++) send_px(5, 5, 5 + j);
    vs_rise(1'b0);
    vsync = 1'b0;
    tick(12);
    chk("tie_A_r", A_r, 78);
    chk("tie_A_g", A_g, 81);
    chk("tie_A_b", A_b, 86);

    // reset in cycle t+3 discards the in-flight result
    for (int i = 0; i < 8; i++) send_px(50, 50, 50);
    vs_rise(1'b0);
    vsync = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    void'(exp_q.pop_back());
    model_reset();
    chk("sum_reset_A_r", A_r, 0);
    chk("sum_reset_busy", busy, 0);
    tick(12);
    for (int i = 0; i < 8; i++) send_px(60, 70, 80);
    vs_rise(1'b0);
    vsync = 1'b0;
    tick(12);
    chk("post_reset_A_r", A_r, 60);
    chk("post_reset_A_g", A_g, 70);
    chk("post_reset_A_b", A_b, 80);

    tick(4);
    chk("results_pending", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/atmos_light_est.md
Name: atmos_light_est

Overview:
- Parametrised successor to the single-value atmospheric-light estimator in the dehaze front end.
- Per frame, tracks the TOP_K pixels with the brightest pixel-wise dark channel, min(r,g,b).
- At frame end, averages those pixels to produce one A value per colour channel (A_r, A_g, A_b).
- Applies optional IIR temporal smoothing across frames, then hands the result to the transmission-estimation stage.

Parameters:
- DATA_WIDTH, 8, bits per colour channel.
- TOP_K, 8, number of brightest dark-channel pixels averaged; must be a power of 2 in 1..32. LOG2_K is derived internally.
- ALPHA_SHIFT, 2, IIR smoothing shift; 0 means no smoothing (A = frame average).

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- vsync  in  1  frame marker; its rising edge ends the current frame and starts the next.
- valid_in  in  1  pixel qualifier.
- r_in, g_in, b_in  in  DATA_WIDTH each  pixel colour.
- A_r, A_g, A_b  out  DATA_WIDTH each  estimated atmospheric light, registered.
- valid_out  out  1  one-cycle pulse when A_* update.
- busy  out  1  high while in SUM or DIV.

Behaviour:
- Clocking: one clock; reset is synchronous and active-high, ports named clk and rst.
- Reset: A_r/A_g/A_b=0, valid_out=0, busy=0, all TOP_K entries invalid, first_frame flag=1, state=ACCUM.
- Live top-K list: TOP_K entries of {valid, dark, r, g, b}, sorted descending by dark.
- Insertion rule: a valid_in pixel with dark value d is inserted at the first position i where the entry is invalid or d > dark[i]. Lower entries shift down one place; the last entry drops.
- Ties: on equal dark, the earlier pixel keeps its position. A new pixel equal to the smallest entry of a full list is discarded.
- Frame end: vsync rise is detected when vsync=1 and the registered vsync_d=0; call this cycle t.
- Cycle t, snapshot: copy the live list to a shadow list, then clear the live list.
- Pixel arriving at cycle t: belongs to the new frame and is inserted into the cleared list in the same cycle.
- Pixels keep accumulating into the live list during SUM/DIV/UPDATE, with no stalls.
- States: ACCUM -> (vsync rise) SUM -> DIV -> UPDATE -> ACCUM.
- SUM (cycles t+1..t+K): add one shadow entry per cycle to three accumulators, each DATA_WIDTH+LOG2_K bits wide. Invalid entries contribute 0. Also count valid entries.
- DIV: avg_c = sum_c >> LOG2_K, truncating.
  - Partial frames are deliberately biased low, because invalid entries count as 0.
- If the valid count is 0 (empty frame): go straight to ACCUM. No valid_out, A_* held, first_frame unchanged.
- UPDATE, first frame after reset: A_c = avg_c, then first_frame cleared.
- UPDATE, later frames: diff = avg_c - A_c as a (DATA_WIDTH+1)-bit signed value, and A_c += diff >>> ALPHA_SHIFT. The shift is arithmetic, rounding toward minus infinity; the result is always in range.
- Latency: A_* update and valid_out=1 at the clock edge ending cycle t+K+2, i.e. visible in cycle t+K+3. valid_out is high for exactly 1 cycle.
- busy=1 from t+1 through the DIV cycle.
- Overlapping frames: a vsync rise while state≠ACCUM is ignored. No snapshot is taken, so the live list continues and the two frames merge into one.
- Held vsync: a high level is not a new rise and must fall before the next frame.
- Reset mid-operation: returns everything to its reset values. An in-flight result is discarded and no valid_out is issued.
- hsync is not needed; the block is line-agnostic.

Test Plan:
- Reset: hold rst 2 cycles mid-stream -> A_*=0, valid_out=0, busy=0. A following frame is treated as the first frame.
- First frame, K=8, ALPHA_SHIFT=2: 16 pixels r=g=b=10·i (i=1..16), then vsync rise at t -> A_r=A_g=A_b=125 (avg of 90..160). valid_out is a single pulse in cycle t+11.
- Smoothing: next frame, all pixels r=g=b=45 -> A_*=125+((45−125)>>>2)=105. A third identical frame -> 105+(−60>>>2)=90.
- Partial and tie handling: fresh reset, 3 pixels (200,210,220), then 10 pixels min=5 -> top-3 dark=200. Sum r=3·200+5·5=625 -> 625>>3=78, g=3·210+25=655 -> 81, b=3·220+25=685 -> 85. A bench variant with ties confirms the earliest equal pixels are kept.
- Empty frame: vsync rise with no valid_in -> no valid_out, A_* unchanged. A second vsync rise during busy is ignored and the merged frame yields one valid_out.
- Reset during SUM (cycle t+3) -> no valid_out, A_*=0, next frame loads its average directly.
